// File: rtl/adder_result_checker_pkg.sv
// Shared FSM state type, default sizes and pipeline depth for the adder result checker.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int PIPE_DEPTH = 2;

endpackage

// File: rtl/adder_result_checker_sat_counter.sv
// CNT_W-bit counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/adder_result_checker.sv
// Scoreboard for WIDTH-bit adders: 2-stage expected-sum compare, saturating counts, pass/fail verdict.
// Optional first-mismatch capture ports are enabled by defining ADDER_CHK_FIRST_FAIL_EN.
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    input  logic [WIDTH-1:0] SUM,
    input  logic             C_OUT,
    output logic             CHK_VALID,
    output logic             CHK_MATCH,
    output logic [CNT_W-1:0] TOT_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             DONE,
    output logic             PASS
`ifdef ADDER_CHK_FIRST_FAIL_EN
    ,
    output logic [WIDTH-1:0] FAIL_A,
    output logic [WIDTH-1:0] FAIL_B,
    output logic             FAIL_CIN,
    output logic [WIDTH:0]   FAIL_SUM,
    output logic [CNT_W-1:0] FAIL_IDX,
    output logic             FAIL_SEEN
`endif
);

    state_e           state_q, state_d;
    logic             clr_cnt;
    logic             accept;
    logic             vld_p1_q, vld_p2_q;
    logic             match_p2_q, match_p2_d;
    logic             mismatch_p1;
    logic [WIDTH:0]   exp_p1_q, exp_p1_d;
    logic [WIDTH:0]   obs_p1_q, obs_p1_d;
    logic [CNT_W-1:0] tot_cnt, err_cnt;

    assign IN_READY = (state_q == RUN);
    assign accept   = IN_VALID & IN_READY;

    // STOP beats START in RUN; the drain ends once stage 1 holds nothing.
    always_comb begin
        state_d = state_q;
        clr_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = RUN;
                    clr_cnt = 1'b1;
                end
            end
            RUN: begin
                if (STOP) begin
                    state_d = DRAIN;
                end else if (START) begin
                    clr_cnt = 1'b1;
                end
            end
            DRAIN: begin
                if (!vld_p1_q) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (START) begin
                    state_d = RUN;
                    clr_cnt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage 1: capture expected and observed values on acceptance.
    always_comb begin
        exp_p1_d = exp_p1_q;
        obs_p1_d = obs_p1_q;
        if (accept) begin
            exp_p1_d = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_IN};
            obs_p1_d = {C_OUT, SUM};
        end
    end

`ifdef ADDER_CHK_FIRST_FAIL_EN
    logic [WIDTH-1:0] a_p1_q, b_p1_q;
    logic             cin_p1_q;
`endif

    always_ff @(posedge CLK) begin
        exp_p1_q <= exp_p1_d;
        obs_p1_q <= obs_p1_d;
`ifdef ADDER_CHK_FIRST_FAIL_EN
        if (accept) begin
            a_p1_q   <= A;
            b_p1_q   <= B;
            cin_p1_q <= C_IN;
        end
`endif
    end

    // Stage 2: compare result and count.
    assign mismatch_p1 = (exp_p1_q != obs_p1_q);
    assign match_p2_d  = vld_p1_q & ~mismatch_p1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            match_p2_q <= 1'b0;
        end else begin
            vld_p1_q   <= accept;
            vld_p2_q   <= vld_p1_q;
            match_p2_q <= match_p2_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_tot_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (clr_cnt),
        .inc (vld_p1_q),
        .cnt (tot_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (clr_cnt),
        .inc (vld_p1_q & mismatch_p1),
        .cnt (err_cnt)
    );

    assign CHK_VALID = vld_p2_q;
    assign CHK_MATCH = vld_p2_q & match_p2_q;
    assign TOT_CNT   = tot_cnt;
    assign ERR_CNT   = err_cnt;
    assign DONE      = (state_q == REPORT);
    assign PASS      = (state_q == REPORT) && (err_cnt == '0);

`ifdef ADDER_CHK_FIRST_FAIL_EN
    logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic             fail_cin_q, fail_cin_d, fail_seen_q, fail_seen_d;
    logic [WIDTH:0]   fail_sum_q, fail_sum_d;
    logic [CNT_W-1:0] fail_idx_q, fail_idx_d;

    // Index is the total count before this sample's own increment.
    always_comb begin
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_cin_d  = fail_cin_q;
        fail_sum_d  = fail_sum_q;
        fail_idx_d  = fail_idx_q;
        fail_seen_d = fail_seen_q;
        if (clr_cnt) begin
            fail_a_d    = '0;
            fail_b_d    = '0;
            fail_cin_d  = 1'b0;
            fail_sum_d  = '0;
            fail_idx_d  = '0;
            fail_seen_d = 1'b0;
        end else if (vld_p1_q && mismatch_p1 && !fail_seen_q) begin
            fail_a_d    = a_p1_q;
            fail_b_d    = b_p1_q;
            fail_cin_d  = cin_p1_q;
            fail_sum_d  = obs_p1_q;
            fail_idx_d  = tot_cnt;
            fail_seen_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_cin_q  <= 1'b0;
            fail_sum_q  <= '0;
            fail_idx_q  <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_cin_q  <= fail_cin_d;
            fail_sum_q  <= fail_sum_d;
            fail_idx_q  <= fail_idx_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign FAIL_A    = fail_a_q;
    assign FAIL_B    = fail_b_q;
    assign FAIL_CIN  = fail_cin_q;
    assign FAIL_SUM  = fail_sum_q;
    assign FAIL_IDX  = fail_idx_q;
    assign FAIL_SEEN = fail_seen_q;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker; a second CNT_W=3 instance shares the stimulus for saturation.
module tb_adder_result_checker;

    localparam int W  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, in_valid, c_in, c_out;
    logic [W-1:0]  a, b, sum;
    logic          in_ready, chk_valid, chk_match, done, pass;
    logic [CW-1:0] tot_cnt, err_cnt;
    logic          s_in_ready, s_chk_valid, s_chk_match, s_done, s_pass;
    logic [2:0]    s_tot, s_err;

    int errors = 0;
    int checks = 0;

`ifdef ADDER_CHK_FIRST_FAIL_EN
    logic [W-1:0]  fail_a, fail_b, s_fail_a, s_fail_b;
    logic          fail_cin, fail_seen, s_fail_cin, s_fail_seen;
    logic [W:0]    fail_sum, s_fail_sum;
    logic [CW-1:0] fail_idx;
    logic [2:0]    s_fail_idx;
`endif

    adder_result_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .C_IN(c_in), .SUM(sum), .C_OUT(c_out),
        .CHK_VALID(chk_valid), .CHK_MATCH(chk_match),
        .TOT_CNT(tot_cnt), .ERR_CNT(err_cnt), .DONE(done), .PASS(pass)
`ifdef ADDER_CHK_FIRST_FAIL_EN
        , .FAIL_A(fail_a), .FAIL_B(fail_b), .FAIL_CIN(fail_cin),
        .FAIL_SUM(fail_sum), .FAIL_IDX(fail_idx), .FAIL_SEEN(fail_seen)
`endif
    );

    adder_result_checker #(.WIDTH(W), .CNT_W(3)) dut_sat (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop),
        .IN_VALID(in_valid), .IN_READY(s_in_ready),
        .A(a), .B(b), .C_IN(c_in), .SUM(sum), .C_OUT(c_out),
        .CHK_VALID(s_chk_valid), .CHK_MATCH(s_chk_match),
        .TOT_CNT(s_tot), .ERR_CNT(s_err), .DONE(s_done), .PASS(s_pass)
`ifdef ADDER_CHK_FIRST_FAIL_EN
        , .FAIL_A(s_fail_a), .FAIL_B(s_fail_b), .FAIL_CIN(s_fail_cin),
        .FAIL_SUM(s_fail_sum), .FAIL_IDX(s_fail_idx), .FAIL_SEEN(s_fail_seen)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic [W-1:0] ts, input logic tco);
        a = ta; b = tb; c_in = tc; sum = ts; c_out = tco; in_valid = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1; start = 0; stop = 0; in_valid = 0;
        a = '0; b = '0; c_in = 0; sum = '0; c_out = 0;
        repeat (2) tick();
        checks++;
        if ({in_ready, chk_valid, chk_match, done, pass, tot_cnt, err_cnt,
             s_in_ready, s_chk_valid, s_chk_match, s_done, s_pass, s_tot, s_err} !== '0)
            begin errors++; $display("FAIL reset_outputs: some output nonzero under reset, expected all 0"); end
        rst = 1'b0;
        tick();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_run_ready: got %b expected 1", in_ready); end
        drive(4'd3, 4'd4, 1'b0, 4'd7, 1'b0);
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, chk_valid, chk_match, done, pass, tot_cnt, err_cnt} !== '0)
            begin errors++; $display("FAIL reset_mid_run: tot=%0d ready=%b valid=%b expected all 0", tot_cnt, in_ready, chk_valid); end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (chk_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || tot_cnt !== '0 || in_ready !== 1'b0)
            begin errors++; $display("FAIL reset_discard: chk_valid_seen=%b tot=%0d ready=%b expected 0/0/0", seen, tot_cnt, in_ready); end
    endtask

    task automatic test_correct();
        pulse_start();
        drive(4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0);
        tick();
        checks++;
        if (chk_valid !== 1'b0) begin errors++; $display("FAIL correct_latency: chk_valid=%b one cycle after accept, expected 0", chk_valid); end
        drive(4'b0011, 4'b0011, 1'b0, 4'b0110, 1'b0);
        tick();
        checks++;
        if (chk_valid !== 1'b1 || chk_match !== 1'b1 || tot_cnt !== 16'd1)
            begin errors++; $display("FAIL correct_s0: valid=%b match=%b tot=%0d expected 1/1/1", chk_valid, chk_match, tot_cnt); end
        drive(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
        stop = 1'b1;
        tick();
        checks++;
        if (chk_valid !== 1'b1 || chk_match !== 1'b1 || tot_cnt !== 16'd2 || in_ready !== 1'b0)
            begin errors++; $display("FAIL correct_s1: valid=%b match=%b tot=%0d ready=%b expected 1/1/2/0", chk_valid, chk_match, tot_cnt, in_ready); end
        in_valid = 1'b0; stop = 1'b0;
        tick();
        checks++;
        if (chk_valid !== 1'b1 || chk_match !== 1'b1 || tot_cnt !== 16'd3 || err_cnt !== 16'd0 || done !== 1'b0)
            begin errors++; $display("FAIL correct_s2: valid=%b match=%b tot=%0d err=%0d done=%b expected 1/1/3/0/0", chk_valid, chk_match, tot_cnt, err_cnt, done); end
        tick();
        checks++;
        if (chk_valid !== 1'b0 || chk_match !== 1'b0 || done !== 1'b1 || pass !== 1'b1 || tot_cnt !== 16'd3)
            begin errors++; $display("FAIL correct_verdict: valid=%b match=%b done=%b pass=%b tot=%0d expected 0/0/1/1/3", chk_valid, chk_match, done, pass, tot_cnt); end
    endtask

    task automatic test_fault();
        pulse_start();
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || tot_cnt !== '0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL fault_restart: done=%b pass=%b tot=%0d ready=%b expected 0/0/0/1", done, pass, tot_cnt, in_ready); end
        drive(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0);
        stop = 1'b1;
        tick();
        in_valid = 1'b0; stop = 1'b0;
        tick();
        checks++;
        if (chk_valid !== 1'b1 || chk_match !== 1'b0 || err_cnt !== 16'd1 || tot_cnt !== 16'd1)
            begin errors++; $display("FAIL fault_compare: valid=%b match=%b err=%0d tot=%0d expected 1/0/1/1", chk_valid, chk_match, err_cnt, tot_cnt); end
        tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b0)
            begin errors++; $display("FAIL fault_verdict: done=%b pass=%b expected 1/0", done, pass); end
`ifdef ADDER_CHK_FIRST_FAIL_EN
        checks++;
        if (fail_seen !== 1'b1 || fail_a !== 4'b1111 || fail_b !== 4'b0001 || fail_cin !== 1'b0 ||
            fail_sum !== 5'b00000 || fail_idx !== 16'd0)
            begin errors++; $display("FAIL fault_capture: seen=%b a=%h b=%h cin=%b sum=%h idx=%0d expected 1/f/1/0/00/0",
                                     fail_seen, fail_a, fail_b, fail_cin, fail_sum, fail_idx); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [8] = '{4'h1, 4'h4, 4'h7, 4'hF, 4'h8, 4'h0, 4'hC, 4'h6};
        logic [W-1:0] tb [8] = '{4'h2, 4'h5, 4'h9, 4'hF, 4'h8, 4'h0, 4'h3, 4'hA};
        logic         tc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] ts [8] = '{4'h3, 4'hA, 4'h0, 4'hF, 4'h0, 4'h1, 4'hF, 4'h1};
        logic         tco[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         exp_v;
        pulse_start();
        checks++;
        if (tot_cnt !== '0 || err_cnt !== '0 || done !== 1'b0)
            begin errors++; $display("FAIL b2b_clear: tot=%0d err=%0d done=%b expected 0/0/0", tot_cnt, err_cnt, done); end
`ifdef ADDER_CHK_FIRST_FAIL_EN
        checks++;
        if (fail_seen !== 1'b0 || fail_a !== '0 || fail_sum !== '0)
            begin errors++; $display("FAIL b2b_capture_clear: seen=%b a=%h sum=%h expected 0/0/00", fail_seen, fail_a, fail_sum); end
`endif
        for (int cyc = 0; cyc < 11; cyc++) begin
            exp_v = (cyc >= 2 && cyc <= 9);
            checks++;
            if (chk_valid !== exp_v || chk_match !== exp_v)
                begin errors++; $display("FAIL b2b_pulse cyc%0d: valid=%b match=%b expected %b/%b", cyc, chk_valid, chk_match, exp_v, exp_v); end
            if (cyc == 9) begin
                checks++;
                if (tot_cnt !== 16'd8 || err_cnt !== 16'd0 || done !== 1'b0)
                    begin errors++; $display("FAIL b2b_count: tot=%0d err=%0d done=%b expected 8/0/0", tot_cnt, err_cnt, done); end
            end
            if (cyc < 8) begin
                drive(ta[cyc], tb[cyc], tc[cyc], ts[cyc], tco[cyc]);
                stop = (cyc == 7);
            end else begin
                in_valid = 1'b0;
                stop = 1'b0;
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || tot_cnt !== 16'd8)
            begin errors++; $display("FAIL b2b_verdict: done=%b pass=%b tot=%0d expected 1/1/8", done, pass, tot_cnt); end
    endtask

    task automatic test_start_stop();
        pulse_start();
        drive(4'd2, 4'd3, 1'b0, 4'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (chk_valid !== 1'b1 || chk_match !== 1'b1 || tot_cnt !== '0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL start_priority: valid=%b match=%b tot=%0d ready=%b expected 1/1/0/1", chk_valid, chk_match, tot_cnt, in_ready); end
        drive(4'd7, 4'd8, 1'b1, 4'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (tot_cnt !== 16'd1) begin errors++; $display("FAIL start_stop_pre: tot=%0d expected 1", tot_cnt); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0 || tot_cnt !== 16'd1)
            begin errors++; $display("FAIL start_stop_drain: ready=%b done=%b tot=%0d expected 0/0/1", in_ready, done, tot_cnt); end
        tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || tot_cnt !== 16'd1)
            begin errors++; $display("FAIL start_stop_report: done=%b pass=%b tot=%0d expected 1/1/1", done, pass, tot_cnt); end
    endtask

    task automatic test_saturation();
        int waited;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            drive(4'(i), 4'd0, 1'b0, 4'(i + 1), 1'b0);
            stop = (i == 8);
            tick();
        end
        in_valid = 1'b0; stop = 1'b0;
        waited = 0;
        while (s_done !== 1'b1 && waited < 6) begin
            tick();
            waited++;
        end
        checks++;
        if (s_done !== 1'b1) begin errors++; $display("FAIL sat_done_timeout: done=%b after %0d cycles expected 1", s_done, waited); end
        checks++;
        if (s_tot !== 3'd7 || s_err !== 3'd7 || s_pass !== 1'b0)
            begin errors++; $display("FAIL sat_counts: tot=%0d err=%0d pass=%b expected 7/7/0", s_tot, s_err, s_pass); end
        checks++;
        if (tot_cnt !== 16'd9 || err_cnt !== 16'd9 || pass !== 1'b0 || done !== 1'b1)
            begin errors++; $display("FAIL sat_wide: tot=%0d err=%0d pass=%b done=%b expected 9/9/0/1", tot_cnt, err_cnt, pass, done); end
`ifdef ADDER_CHK_FIRST_FAIL_EN
        checks++;
        if (fail_idx !== 16'd0 || fail_a !== 4'd0 || fail_sum !== 5'd1 || s_fail_idx !== 3'd0 || s_fail_seen !== 1'b1 ||
            s_fail_a !== 4'd0 || s_fail_b !== 4'd0 || s_fail_cin !== 1'b0 || s_fail_sum !== 5'd1)
            begin errors++; $display("FAIL sat_capture: idx=%0d a=%h sum=%h s_idx=%0d expected 0/0/01/0", fail_idx, fail_a, fail_sum, s_fail_idx); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        test_reset();
        test_correct();
        test_fault();
        test_back_to_back();
        test_start_stop();
        test_saturation();
        repeat (adder_chk_pkg::PIPE_DEPTH) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
